// File: rtl/rv_bus_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding and sizes.
package rv_bus_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int TMO_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rv_rr_pick.sv
// Two-way request picker: round-robin against the last-grant pointer, or fixed
// priority with master 0 highest.
module rv_rr_pick
    import rv_bus_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last,
    output logic [NUM_MASTERS-1:0] gnt
);

    // last = 1 means master 1 was granted most recently, so master 0 goes next.
    always_comb begin
        gnt = '0;
        if (req[0] && req[1]) begin
            if (RR && !last) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/rv_bus_arb.sv
// Two-master Wishbone-style bus arbiter with cycle-level ownership and a
// per-transfer ack timeout that aborts a stuck master.
module rv_bus_arb
    import rv_bus_pkg::*;
#(
    parameter bit          RR      = 1'b1,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [29:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [29:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [29:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  grant_o,
    output arb_state_t  state_o
);

    // Handshake: a master requests with cyc&stb; a beat completes on the cycle
    // the slave raises ack while that master owns the bus. TIMEOUT is 1..65535.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] CNT_ONE  = TMO_W'(1);

    arb_state_t             state, state_nx;
    logic                   last, last_nx;
    logic [TMO_W-1:0]       cnt, cnt_nx;
    logic [NUM_MASTERS-1:0] req, pick;

    assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

    rv_rr_pick #(.RR(RR)) u_pick (
        .req  (req),
        .last (last),
        .gnt  (pick)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    // Slave side mirrors the owner combinationally; idle/abort drive zeros.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        case (state)
            ST_OWN0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            ST_OWN1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (pick[0]) begin
                    state_nx = ST_OWN0;
                    last_nx  = 1'b0;
                    cnt_nx   = '0;
                end else if (pick[1]) begin
                    state_nx = ST_OWN1;
                    last_nx  = 1'b1;
                    cnt_nx   = '0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                // Ownership lasts for the whole cycle; an ack on the final
                // count still completes the beat instead of aborting.
                if (!s_cyc_o) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else if (s_ack_i) begin
                    cnt_nx = '0;
                end else if (s_stb_o) begin
                    if (cnt == TMO_LAST) begin
                        state_nx = ST_ABORT;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
            end
            ST_ABORT: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // The pointer still names the aborted owner while in ABORT.
    assign m0_ack_o = s_ack_i & (state == ST_OWN0);
    assign m1_ack_o = s_ack_i & (state == ST_OWN1);
    assign m0_err_o = (state == ST_ABORT) & ~last;
    assign m1_err_o = (state == ST_ABORT) & last;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = {state == ST_OWN1, state == ST_OWN0};
    assign state_o  = state;

endmodule

// File: tb/tb_rv_bus_arb.sv
// Bench for rv_bus_arb: a round-robin and a fixed-priority instance share
// stimulus; each is checked every cycle against a transaction-level model.
module tb_rv_bus_arb;
    import rv_bus_pkg::*;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        mc [2];
    logic        ms [2];
    logic        mw [2];
    logic [3:0]  msel [2];
    logic [29:0] madr [2];
    logic [31:0] mdat [2];
    logic        sack;
    logic [31:0] sdat;

    logic        o_cyc [2];
    logic        o_stb [2];
    logic        o_we [2];
    logic [3:0]  o_sel [2];
    logic [29:0] o_adr [2];
    logic [31:0] o_dat [2];
    logic        o_ack0 [2];
    logic        o_ack1 [2];
    logic        o_err0 [2];
    logic        o_err1 [2];
    logic [31:0] o_rd0 [2];
    logic [31:0] o_rd1 [2];
    logic [1:0]  o_gnt [2];
    arb_state_t  o_st [2];

    int total = 0;
    int bad   = 0;

    // Model per instance: owner (-1 none), most recent winner, unacked strobe
    // cycles so far, and a one-cycle abort flag with the aborted master.
    int own [2];
    int last_win [2];
    int waits [2];
    bit abort_now [2];
    int abort_who [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rv_bus_arb #(.RR(g == 0), .TIMEOUT(TMO)) dut (
            .clk_i    (clk),
            .rstn_i   (rstn),
            .m0_cyc_i (mc[0]),
            .m0_stb_i (ms[0]),
            .m0_we_i  (mw[0]),
            .m0_sel_i (msel[0]),
            .m0_adr_i (madr[0]),
            .m0_dat_i (mdat[0]),
            .m0_dat_o (o_rd0[g]),
            .m0_ack_o (o_ack0[g]),
            .m0_err_o (o_err0[g]),
            .m1_cyc_i (mc[1]),
            .m1_stb_i (ms[1]),
            .m1_we_i  (mw[1]),
            .m1_sel_i (msel[1]),
            .m1_adr_i (madr[1]),
            .m1_dat_i (mdat[1]),
            .m1_dat_o (o_rd1[g]),
            .m1_ack_o (o_ack1[g]),
            .m1_err_o (o_err1[g]),
            .s_cyc_o  (o_cyc[g]),
            .s_stb_o  (o_stb[g]),
            .s_we_o   (o_we[g]),
            .s_sel_o  (o_sel[g]),
            .s_adr_o  (o_adr[g]),
            .s_dat_o  (o_dat[g]),
            .s_ack_i  (sack),
            .s_dat_i  (sdat),
            .grant_o  (o_gnt[g]),
            .state_o  (o_st[g])
        );
    end

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k]       = -1;
            last_win[k]  = 1;
            waits[k]     = 0;
            abort_now[k] = 1'b0;
            abort_who[k] = 0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [6:0]  ectl;
            logic [29:0] eadr;
            logic [31:0] edat;
            logic [1:0]  egnt;
            logic [3:0]  eresp;
            ectl = '0;
            eadr = '0;
            edat = '0;
            egnt = 2'b00;
            if (own[k] >= 0) begin
                ectl = {mc[own[k]], ms[own[k]], mw[own[k]], msel[own[k]]};
                eadr = madr[own[k]];
                edat = mdat[own[k]];
                egnt = (own[k] == 0) ? 2'b01 : 2'b10;
            end
            eresp = {abort_now[k] && abort_who[k] == 1, abort_now[k] && abort_who[k] == 0,
                     own[k] == 1 && sack, own[k] == 0 && sack};
            chk("ctrl", k, {o_cyc[k], o_stb[k], o_we[k], o_sel[k]}, ectl);
            chk("adr", k, o_adr[k], eadr);
            chk("wdat", k, o_dat[k], edat);
            chk("resp", k, {o_err1[k], o_err0[k], o_ack1[k], o_ack0[k]}, eresp);
            chk("grant", k, o_gnt[k], egnt);
            chk("rdat", k, {o_rd1[k], o_rd0[k]}, {sdat, sdat});
        end
    endtask

    task automatic model_update();
        if (!rstn) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (abort_now[k]) begin
                abort_now[k] = 1'b0;
            end else if (own[k] < 0) begin
                bit r0, r1;
                int w;
                r0 = mc[0] && ms[0];
                r1 = mc[1] && ms[1];
                w  = -1;
                if (r0 && r1)  w = (k == 0) ? 1 - last_win[k] : 0;
                else if (r0)   w = 0;
                else if (r1)   w = 1;
                if (w >= 0) begin
                    own[k]      = w;
                    last_win[k] = w;
                    waits[k]    = 0;
                end
            end else if (!mc[own[k]]) begin
                own[k] = -1;
            end else if (sack) begin
                waits[k] = 0;
            end else if (ms[own[k]]) begin
                waits[k]++;
                if (waits[k] == TMO) begin
                    abort_now[k] = 1'b1;
                    abort_who[k] = own[k];
                    own[k]       = -1;
                    waits[k]     = 0;
                end
            end
        end
    endtask

    task automatic half_check();
        @(negedge clk);
        check_all();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        half_check();
        edge_step();
    endtask

    task automatic idle_masters();
        for (int n = 0; n < 2; n++) begin
            mc[n] = 1'b0;
            ms[n] = 1'b0;
            mw[n] = 1'b0;
        end
        sack = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        for (int n = 0; n < 2; n++) begin
            mc[n] = 1'b1;
            ms[n] = 1'b1;
            mw[n] = 1'b1;
            msel[n] = 4'hf;
            madr[n] = 30'h3;
            mdat[n] = 32'h1234_5678;
        end
        sack = 1'b1;
        sdat = 32'h0;
        model_reset();

        // Reset holds everything idle even with requests and ack present.
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_cyc", k, o_cyc[k], 1'b0);
            chk("rst_gnt", k, o_gnt[k], 2'b00);
            chk("rst_st", k, o_st[k], ST_IDLE);
        end
        tick();
        tick();
        idle_masters();
        rstn = 1'b1;
        tick();

        // Single m0 read of byte address 0x100, acked two cycles after stb.
        mc[0] = 1'b1; ms[0] = 1'b1; mw[0] = 1'b0; msel[0] = 4'hf; madr[0] = 30'h40;
        sdat = 32'hdead_beef;
        tick();
        half_check();
        for (int k = 0; k < 2; k++) begin
            chk("rd_adr", k, o_adr[k], 30'h40);
            chk("rd_gnt", k, o_gnt[k], 2'b01);
        end
        edge_step();
        sack = 1'b1;
        half_check();
        for (int k = 0; k < 2; k++) chk("rd_ack", k, {o_ack1[k], o_ack0[k]}, 2'b01);
        edge_step();
        sack = 1'b0; mc[0] = 1'b0; ms[0] = 1'b0;
        half_check();
        for (int k = 0; k < 2; k++) chk("rd_cycdrop", k, o_cyc[k], 1'b0);
        edge_step();
        half_check();
        for (int k = 0; k < 2; k++) chk("rd_gnt_end", k, o_gnt[k], 2'b00);
        edge_step();

        // Both masters re-request every third cycle with the slave always acking.
        do_reset();
        for (int t = 0; t < 12; t++) begin
            mc[0] = (t % 3 != 2); ms[0] = mc[0];
            mc[1] = (t % 3 != 2); ms[1] = mc[1];
            sack  = 1'b1;
            half_check();
            if (t % 3 == 1) begin
                chk("rr_order", 0, o_gnt[0], ((t / 3) % 2 == 1) ? 2'b10 : 2'b01);
                chk("fp_order", 1, o_gnt[1], 2'b01);
            end
            if (t % 3 == 0) begin
                for (int k = 0; k < 2; k++) chk("bubble", k, o_gnt[k], 2'b00);
            end
            edge_step();
        end
        idle_masters();
        tick();
        tick();

        // m1 holds cyc across a read, a strobe gap and a write while m0 waits.
        mc[1] = 1'b1; ms[1] = 1'b1; mw[1] = 1'b0; madr[1] = 30'h80; msel[1] = 4'h3;
        tick();
        mc[0] = 1'b1; ms[0] = 1'b1; sack = 1'b1;
        half_check();
        for (int k = 0; k < 2; k++) chk("hold_rd", k, {o_gnt[k], o_ack1[k]}, 3'b101);
        edge_step();
        ms[1] = 1'b0; sack = 1'b0;
        half_check();
        for (int k = 0; k < 2; k++) chk("hold_gap", k, o_gnt[k], 2'b10);
        edge_step();
        ms[1] = 1'b1; mw[1] = 1'b1; mdat[1] = 32'hcafe_0001; sack = 1'b1;
        half_check();
        for (int k = 0; k < 2; k++) chk("hold_wr", k, {o_gnt[k], o_we[k], o_dat[k]}, {2'b10, 1'b1, 32'hcafe_0001});
        edge_step();
        mc[1] = 1'b0; ms[1] = 1'b0; mw[1] = 1'b0; sack = 1'b0;
        tick();
        tick();
        half_check();
        for (int k = 0; k < 2; k++) chk("hold_m0", k, o_gnt[k], 2'b01);
        edge_step();
        idle_masters();
        tick();
        tick();

        // Slave never acks: abort after four strobe cycles.
        mc[0] = 1'b1; ms[0] = 1'b1;
        tick();
        for (int i = 0; i < TMO; i++) tick();
        mc[0] = 1'b0; ms[0] = 1'b0;
        half_check();
        for (int k = 0; k < 2; k++) chk("tmo_abort", k, {o_err0[k], o_cyc[k], o_gnt[k]}, 4'b1000);
        edge_step();
        half_check();
        for (int k = 0; k < 2; k++) chk("tmo_after", k, {o_err0[k], o_st[k]}, {1'b0, ST_IDLE});
        edge_step();

        // Ack on the fourth strobe cycle wins over the timeout.
        mc[0] = 1'b1; ms[0] = 1'b1;
        tick();
        for (int i = 0; i < TMO - 1; i++) tick();
        sack = 1'b1;
        half_check();
        for (int k = 0; k < 2; k++) chk("tmo_ack", k, {o_err0[k], o_ack0[k]}, 2'b01);
        edge_step();
        idle_masters();
        half_check();
        for (int k = 0; k < 2; k++) chk("tmo_noerr", k, o_err0[k], 1'b0);
        edge_step();
        tick();

        // Randomized traffic with sticky cycles and a sometimes-slow slave.
        for (int t = 0; t < 600; t++) begin
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 3) == 0) mc[n] = ~mc[n];
                ms[n]   = mc[n] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
                mw[n]   = $urandom_range(0, 1) == 1;
                msel[n] = 4'($urandom_range(0, 15));
                madr[n] = 30'($urandom);
                mdat[n] = $urandom;
            end
            sack = ($urandom_range(0, 2) == 0);
            sdat = $urandom;
            tick();
        end
        idle_masters();
        tick();
        tick();
        tick();

        // Reset in the middle of an m1 write, with the slave acking.
        mc[1] = 1'b1; ms[1] = 1'b1; mw[1] = 1'b1; madr[1] = 30'h123; mdat[1] = 32'h5a5a_a5a5;
        tick();
        sack = 1'b1;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_mid", k, {o_cyc[k], o_stb[k], o_gnt[k]}, 4'b0000);
            chk("rst_resp", k, {o_err1[k], o_err0[k], o_ack1[k], o_ack0[k]}, 4'b0000);
        end
        tick();
        mc[0] = 1'b1; ms[0] = 1'b1; sack = 1'b0;
        rstn = 1'b1;
        tick();
        half_check();
        for (int k = 0; k < 2; k++) chk("rst_first", k, o_gnt[k], 2'b01);
        edge_step();
        idle_masters();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_bus_arb.md
RV_BUS_ARB -- requirements
Module: rv_bus_arb

Interface
REQ-001 Parameter RR, default 1: 1 = round-robin arbitration, 0 = fixed priority with m0 highest.
REQ-002 Parameter TIMEOUT, default 1023: cycles without s_ack_i before a granted transfer is aborted; range 1..65535.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rstn_i  in  1  reset, asynchronous assertion, active-low.
REQ-005 mN_cyc_i  in  1  (N=0,1) master N bus cycle request; held across multi-beat sequences.
REQ-006 mN_stb_i  in  1  master N strobe.
REQ-007 mN_we_i  in  1  master N write enable.
REQ-008 mN_sel_i  in  4  master N byte selects.
REQ-009 mN_adr_i  in  30  master N word address [31:2].
REQ-010 mN_dat_i  in  32  master N write data.
REQ-011 mN_dat_o  out  32  read data to master N; equals s_dat_i for both masters.
REQ-012 mN_ack_o  out  1  transfer acknowledge to master N.
REQ-013 mN_err_o  out  1  timeout abort to master N, single-cycle pulse.
REQ-014 s_cyc_o, s_stb_o, s_we_o  out  1 each  slave bus control.
REQ-015 s_sel_o  out  4;  s_adr_o  out  30;  s_dat_o  out  32  slave bus byte selects, word address and write data.
REQ-016 s_ack_i  in  1;  s_dat_i  in  32  slave acknowledge and read data.
REQ-017 grant_o  out  2  one-hot current owner; 00 when no master owns the bus.

Function
REQ-018 The FSM SHALL have states IDLE, OWN0, OWN1 and ABORT, with the state register reset to IDLE.
REQ-019 In IDLE, a request (mN_cyc_i & mN_stb_i) SHALL move the FSM to OWNN on the next edge, so slave signals appear one cycle after the request.
REQ-020 When both masters request in IDLE with RR=1, the master not granted most recently SHALL win; the last-grant pointer resets to m1, so m0 wins first.
REQ-021 When both masters request in IDLE with RR=0, m0 SHALL win.
REQ-022 In OWNN, the s_* outputs SHALL combinationally mirror master N: s_cyc_o = mN_cyc_i, s_stb_o = mN_stb_i, and so on. In IDLE and ABORT all s_* control outputs, s_sel_o and s_adr_o SHALL be 0.
REQ-023 mN_ack_o SHALL equal s_ack_i & (state==OWNN); s_ack_i in any other state SHALL be ignored.
REQ-024 Ownership SHALL persist while mN_cyc_i=1, so strobe gaps within one cycle (read-modify-write) are not preempted.
REQ-025 When mN_cyc_i falls, s_cyc_o SHALL fall in the same cycle and the FSM SHALL return to IDLE on the next edge, giving a one-idle-cycle bubble between owners.
REQ-026 A 16-bit timeout counter SHALL clear on entry to OWNN and on each s_ack_i, and SHALL increment while s_stb_o=1 & s_ack_i=0.
REQ-027 When the counter equals TIMEOUT-1 with no ack, the FSM SHALL enter ABORT.
REQ-028 In ABORT, mN_err_o SHALL pulse for exactly one cycle, s_cyc_o SHALL be 0, and the FSM SHALL then go to IDLE.
REQ-029 If s_ack_i arrives in the same cycle the counter reaches TIMEOUT-1, the ack SHALL win: no abort occurs and the counter clears.
REQ-030 The last-grant pointer SHALL update only on an IDLE to OWNN transition.

Reset
REQ-031 While rstn_i=0: state = IDLE, counter = 0, pointer = m1, all mN_ack_o, mN_err_o, s_cyc_o, s_stb_o and grant_o = 0, independent of clk_i.
REQ-032 Reset asserted mid-transfer SHALL drop s_cyc_o immediately and SHALL NOT produce an ack or err pulse.
REQ-033 After reset release, the first arbitration SHALL occur on the first clk_i edge that sees a request.

Structure
REQ-034 Package rv_bus_pkg SHALL hold the FSM state encoding, NUM_MASTERS=2 and TMO_W=16.
REQ-035 Arbitration SHALL live in the sub-module rv_rr_pick (request vector plus pointer in, one-hot grant out, RR/fixed selected by parameter); the FSM, timeout counter and muxing stay in rv_bus_arb.

Verification
REQ-036 m0 reads 0x100 alone and the slave acks 2 cycles after stb: s_adr_o=0x40 one cycle after the request, m0_ack_o=1 for one cycle, m1_ack_o=0, grant_o=01 then 00.
REQ-037 Both masters request continuously with RR=1: grant order m0, m1, m0, m1 with one idle cycle between owners; with RR=0, m0 keeps winning whenever it re-requests.
REQ-038 m1 holds cyc across a read beat and a write beat to 0x200 with one stb-low gap while m0 requests: m0 is not granted until m1_cyc_i falls.
REQ-039 TIMEOUT=4 and the slave never acks: m0_err_o pulses once after 4 strobe cycles, s_cyc_o=0 in ABORT, then IDLE; an ack arriving on the 4th cycle gives ack and no err.
REQ-040 rstn_i pulled low during an m1 write: s_cyc_o=0 before the next clk_i edge, no ack or err pulse, grant_o=00, and the next simultaneous request is won by m0.
